// File: rtl/pipe_int_ctrl_if.sv
// Interrupt sequencer bus for pipe_int_ctrl.
// Groups every non-clock, non-reset signal of the sequencer.
//   master : pipeline side. Drives requests, mask writes, stall/mret/epc and
//            consumes the pulses, redirect and status.
//   slave  : sequencer side (pipe_int_ctrl).
// NUM_SRC must match the NUM_SRC of the attached pipe_int_ctrl.
interface pipe_int_ctrl_if #(
   parameter int unsigned NUM_SRC = 4
) ();

   logic [NUM_SRC-1:0] int_src;
   logic               cfg_we;
   logic [NUM_SRC-1:0] cfg_wdata;
   logic               stall_i;
   logic               mret_i;
   logic [31:0]        epc_i;

   logic               int_detected;
   logic               int_restore;
   logic [NUM_SRC-1:0] int_ack;
   logic               redirect_valid;
   logic [31:0]        redirect_pc;
   logic [31:0]        epc;
   logic [3:0]         cause;
   logic               in_handler;
   logic [NUM_SRC-1:0] mask_q;

   modport master (
      output int_src, cfg_we, cfg_wdata, stall_i, mret_i, epc_i,
      input  int_detected, int_restore, int_ack, redirect_valid, redirect_pc,
      input  epc, cause, in_handler, mask_q
   );

   modport slave (
      input  int_src, cfg_we, cfg_wdata, stall_i, mret_i, epc_i,
      output int_detected, int_restore, int_ack, redirect_valid, redirect_pc,
      output epc, cause, in_handler, mask_q
   );

endinterface

// File: rtl/pipe_int_ctrl.sv
// Interrupt sequencer for the 5-stage pipeline.
// Picks the lowest-numbered pending, unmasked source once the pipeline is not
// stalled, pulses int_detected (stage registers back up and clear) and
// redirects fetch to the handler vector. When the handler's mret retires
// unstalled it pulses int_restore (stage registers reload) and redirects
// fetch to the saved PC. No nesting: requests wait at the source while busy.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : pipe_int_ctrl_if.slave (requests, mask write, stall/mret/epc in;
//           pulses, ack, redirect, epc, cause, in_handler, mask out)
module pipe_int_ctrl #(
   parameter int unsigned        NUM_SRC    = 4,
   parameter logic [31:0]        VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0]        VEC_STRIDE = 32'h0000_0004,
   parameter logic [NUM_SRC-1:0] MASK_RST   = '1
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_int_ctrl_if.slave       bus
);

   typedef enum logic [1:0] {
      StIdle,
      StSave,
      StHandler,
      StRestore
   } state_e;

   state_e             state_q, state_d;
   logic [31:0]        epc_q, epc_d;
   logic [3:0]         cause_q, cause_d;
   logic [NUM_SRC-1:0] mask_reg_q;
   logic [NUM_SRC-1:0] pending;
   logic [3:0]         lowest;

   // Detection always sees the registered mask; a write lands next cycle.
   assign pending = bus.int_src & mask_reg_q;

   always_comb begin
      lowest = '0;
      // Descending scan so the lowest set bit wins.
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         if (pending[i]) lowest = 4'(i);
      end
   end

   always_comb begin
      state_d            = state_q;
      epc_d              = epc_q;
      cause_d            = cause_q;
      bus.int_detected   = 1'b0;
      bus.int_restore    = 1'b0;
      bus.int_ack        = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.in_handler     = 1'b0;

      case (state_q)
         StIdle: begin
            if ((pending != '0) && !bus.stall_i) begin
               cause_d = lowest;
               epc_d   = bus.epc_i;
               state_d = StSave;
            end
         end
         StSave: begin
            bus.int_detected   = 1'b1;
            bus.int_ack        = NUM_SRC'(1) << cause_q;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = VEC_BASE + VEC_STRIDE * {28'd0, cause_q};
            state_d            = StHandler;
         end
         StHandler: begin
            bus.in_handler = 1'b1;
            if (bus.mret_i && !bus.stall_i) state_d = StRestore;
         end
         StRestore: begin
            bus.int_restore    = 1'b1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = epc_q;
            state_d            = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         epc_q      <= '0;
         cause_q    <= '0;
         mask_reg_q <= MASK_RST;
      end else begin
         state_q <= state_d;
         epc_q   <= epc_d;
         cause_q <= cause_d;
         if (bus.cfg_we) mask_reg_q <= bus.cfg_wdata;
      end
   end

   assign bus.epc    = epc_q;
   assign bus.cause  = cause_q;
   assign bus.mask_q = mask_reg_q;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Self-checking bench for pipe_int_ctrl (NUM_SRC = 4, default vectors).
module tb_pipe_int_ctrl;

   localparam int unsigned N  = 4;
   localparam logic [31:0] VB = 32'h0000_0100;
   localparam logic [31:0] VS = 32'h0000_0004;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipe_int_ctrl_if #(.NUM_SRC(N)) bus ();

   pipe_int_ctrl #(.NUM_SRC(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [3:0]  src;
      logic        we;
      logic [3:0]  wdata;
      logic        stall;
      logic        mret;
      logic [31:0] epc_in;
      logic [79:0] exp;
   } vec_t;

   vec_t tbl[18];

   // Reference model state
   logic [3:0]  m_mask;
   logic [31:0] m_epc;
   logic [3:0]  m_cause;
   logic        m_active; // interrupt taken and not yet returned
   logic        m_det;    // this cycle carries the detect pulse
   logic        m_ret;    // this cycle carries the restore pulse

   function automatic logic [79:0] pk(logic det, logic rs, logic [3:0] ack, logic rv,
                                      logic [31:0] rpc, logic [3:0] cause, logic [31:0] epc,
                                      logic inh, logic [3:0] mask);
      return {det, rs, ack, rv, rpc, cause, epc, inh, mask};
   endfunction

   function automatic logic [79:0] obs();
      return {bus.int_detected, bus.int_restore, bus.int_ack, bus.redirect_valid,
              bus.redirect_pc, bus.cause, bus.epc, bus.in_handler, bus.mask_q};
   endfunction

   function automatic vec_t mk(logic [3:0] src, logic we, logic [3:0] wdata, logic stall,
                               logic mret, logic [31:0] epc_in, logic [79:0] exp);
      vec_t v;
      v.src = src; v.we = we; v.wdata = wdata; v.stall = stall;
      v.mret = mret; v.epc_in = epc_in; v.exp = exp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (det,rst,ack,rv,rpc,cause,epc,inh,mask)",
                    name, act, exp);
   endtask

   task automatic drive(input logic [3:0] src, input logic we, input logic [3:0] wdata,
                        input logic stall, input logic mret, input logic [31:0] epc_in);
      bus.int_src   = src;
      bus.cfg_we    = we;
      bus.cfg_wdata = wdata;
      bus.stall_i   = stall;
      bus.mret_i    = mret;
      bus.epc_i     = epc_in;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   function automatic logic [79:0] m_exp();
      logic [31:0] rpc;
      rpc = m_det ? (VB + VS * {28'd0, m_cause}) : (m_ret ? m_epc : 32'h0);
      return pk(m_det, m_ret, m_det ? (4'b0001 << m_cause) : 4'h0, m_det | m_ret, rpc,
                m_cause, m_epc, m_active & ~m_det, m_mask);
   endfunction

   task automatic m_reset();
      m_mask = 4'hF; m_epc = '0; m_cause = '0;
      m_active = 1'b0; m_det = 1'b0; m_ret = 1'b0;
   endtask

   // Advance the model by one clock given this cycle's inputs.
   task automatic m_step(input logic [3:0] src, input logic we, input logic [3:0] wdata,
                         input logic stall, input logic mret, input logic [31:0] epc_in);
      logic [3:0] pend, iso;
      pend = src & m_mask;
      if (we) m_mask = wdata;
      if (m_det) begin
         m_det = 1'b0;
      end else if (m_active) begin
         if (mret && !stall) begin
            m_active = 1'b0;
            m_ret    = 1'b1;
         end
      end else if (m_ret) begin
         m_ret = 1'b0;
      end else if (pend != 4'h0 && !stall) begin
         iso = pend & (~pend + 4'd1);
         for (int k = 0; k < 4; k++) if (iso[k]) m_cause = 4'(k);
         m_epc    = epc_in;
         m_active = 1'b1;
         m_det    = 1'b1;
      end
   endtask

   initial begin
      logic [3:0]  r_src, r_wd;
      logic        r_we, r_st, r_mr;
      logic [31:0] r_epc;

      //            src     we    wdata  stall mret  epc_in
      tbl[0]  = mk(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h40,
                   pk(1, 0, 4'b0100, 1, 32'h108, 4'd2, 32'h40, 0, 4'hF));
      tbl[1]  = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h40, 1, 4'hF));
      tbl[2]  = mk(4'b0000, 1'b0, 4'h0, 1'b1, 1'b1, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h40, 1, 4'hF));
      tbl[3]  = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 1, 4'h0, 1, 32'h40, 4'd2, 32'h40, 0, 4'hF));
      tbl[4]  = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h40, 0, 4'hF));
      tbl[5]  = mk(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0, 32'h80,
                   pk(1, 0, 4'b0010, 1, 32'h104, 4'd1, 32'h80, 0, 4'hF));
      tbl[6]  = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd1, 32'h80, 1, 4'hF));
      tbl[7]  = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 1, 4'h0, 1, 32'h80, 4'd1, 32'h80, 0, 4'hF));
      tbl[8]  = mk(4'b0000, 1'b1, 4'hD, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd1, 32'h80, 0, 4'hD));
      tbl[9]  = mk(4'b1010, 1'b0, 4'h0, 1'b0, 1'b0, 32'hC0,
                   pk(1, 0, 4'b1000, 1, 32'h10C, 4'd3, 32'hC0, 0, 4'hD));
      tbl[10] = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd3, 32'hC0, 1, 4'hD));
      tbl[11] = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 1, 4'h0, 1, 32'hC0, 4'd3, 32'hC0, 0, 4'hD));
      tbl[12] = mk(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd3, 32'hC0, 0, 4'hD));
      // Mask write in the detect cycle: old mask still admits source 2.
      tbl[13] = mk(4'b0100, 1'b1, 4'h0, 1'b0, 1'b0, 32'h200,
                   pk(1, 0, 4'b0100, 1, 32'h108, 4'd2, 32'h200, 0, 4'h0));
      tbl[14] = mk(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h200, 1, 4'h0));
      tbl[15] = mk(4'b0100, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0,
                   pk(0, 1, 4'h0, 1, 32'h200, 4'd2, 32'h200, 0, 4'h0));
      tbl[16] = mk(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h200, 0, 4'h0));
      // Re-enable: this cycle still uses the all-zero mask.
      tbl[17] = mk(4'b0100, 1'b1, 4'hF, 1'b0, 1'b0, 32'h0,
                   pk(0, 0, 4'h0, 0, 32'h0, 4'd2, 32'h200, 0, 4'hF));

      do_reset();
      chk("reset_state", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h0, 0, 4'hF));

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].src, tbl[i].we, tbl[i].wdata, tbl[i].stall, tbl[i].mret, tbl[i].epc_in);
         step();
         chk($sformatf("vec%0d", i), obs(), tbl[i].exp);
      end

      // Stall hold-off
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(4'b0001, 1'b0, 4'h0, 1'b1, 1'b0, 32'h1000 + i);
         step();
         chk("stall_hold", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h0, 0, 4'hF));
      end
      drive(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 32'h5555);
      step();
      chk("stall_release", obs(), pk(1, 0, 4'b0001, 1, 32'h100, 4'd0, 32'h5555, 0, 4'hF));

      // No nesting: source 0 stays high throughout the handler.
      for (int i = 0; i < 4; i++) begin
         drive(4'b0001, i == 1, 4'h3, 1'b0, 1'b0, 32'h9999);
         step();
         chk("no_nest", obs(),
             pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h5555, 1, (i >= 1) ? 4'h3 : 4'hF));
      end
      drive(4'b0001, 1'b0, 4'h0, 1'b0, 1'b1, 32'h9999);
      step();
      chk("b2b_restore", obs(), pk(0, 1, 4'h0, 1, 32'h5555, 4'd0, 32'h5555, 0, 4'h3));
      drive(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 32'h6666);
      step();
      chk("b2b_gap", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h5555, 0, 4'h3));
      step();
      chk("b2b_detect", obs(), pk(1, 0, 4'b0001, 1, 32'h100, 4'd0, 32'h6666, 0, 4'h3));
      drive(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 32'h0);
      step();
      chk("b2b_handler", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h6666, 1, 4'h3));

      // Asynchronous reset mid-handler, between clock edges.
      #2;
      reset = 1'b1;
      #1;
      chk("async_reset", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h0, 0, 4'hF));
      step();
      reset = 1'b0;
      drive(4'b0000, 1'b0, 4'h0, 1'b0, 1'b1, 32'h0);
      step();
      chk("no_restore_after_reset", obs(), pk(0, 0, 4'h0, 0, 32'h0, 4'd0, 32'h0, 0, 4'hF));
      drive(4'b0100, 1'b0, 4'h0, 1'b0, 1'b0, 32'h7000);
      step();
      chk("post_reset_service", obs(),
          pk(1, 0, 4'b0100, 1, 32'h108, 4'd2, 32'h7000, 0, 4'hF));

      // Randomized run against the reference model.
      do_reset();
      m_reset();
      chk("rand_reset", obs(), m_exp());
      for (int c = 0; c < 400; c++) begin
         r_src = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         r_we  = ($urandom_range(0, 15) == 0);
         r_wd  = 4'($urandom);
         r_st  = ($urandom_range(0, 3) == 0);
         r_mr  = ($urandom_range(0, 2) == 0);
         r_epc = $urandom;
         drive(r_src, r_we, r_wd, r_st, r_mr, r_epc);
         m_step(r_src, r_we, r_wd, r_st, r_mr, r_epc);
         step();
         chk($sformatf("rand%0d", c), obs(), m_exp());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
